// File: rtl/regfile_issue_if.sv
// regfile_issue_if: bundle of every non-clock signal around the operand-issue
// stage.
//   decode    : dec_valid/dec_ready handshake, dec_raddr1/2, dec_waddr, dec_wen, dec_tag
//   regfile   : rf_raddr1/2, rf_waddr, rf_wdata, rf_wren out; rf_rs1/2 back (1-cycle latency)
//   writeback : wb_valid, wb_addr, wb_data
//   execute   : ex_valid/ex_ready handshake, ex_rs1/2, ex_waddr, ex_wen, ex_tag
// Modports:
//   slave  - the issue stage itself
//   master - its environment (decode, regfile, writeback source, execute)
interface regfile_issue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 32
);
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_raddr1;
  logic [ADDR_W-1:0] dec_raddr2;
  logic [ADDR_W-1:0] dec_waddr;
  logic              dec_wen;
  logic [TAG_W-1:0]  dec_tag;

  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wren;
  logic [DATA_W-1:0] rf_rs1;
  logic [DATA_W-1:0] rf_rs2;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_rs1;
  logic [DATA_W-1:0] ex_rs2;
  logic [ADDR_W-1:0] ex_waddr;
  logic              ex_wen;
  logic [TAG_W-1:0]  ex_tag;

  modport slave (
    input  dec_valid, dec_raddr1, dec_raddr2, dec_waddr, dec_wen, dec_tag,
    output dec_ready,
    output rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wren,
    input  rf_rs1, rf_rs2,
    input  wb_valid, wb_addr, wb_data,
    output ex_valid, ex_rs1, ex_rs2, ex_waddr, ex_wen, ex_tag,
    input  ex_ready
  );

  modport master (
    output dec_valid, dec_raddr1, dec_raddr2, dec_waddr, dec_wen, dec_tag,
    input  dec_ready,
    input  rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_wren,
    output rf_rs1, rf_rs2,
    output wb_valid, wb_addr, wb_data,
    input  ex_valid, ex_rs1, ex_rs2, ex_waddr, ex_wen, ex_tag,
    output ex_ready
  );
endinterface

// File: rtl/regfile_issue.sv
// regfile_issue: operand-issue stage in front of a 2^ADDR_W-entry regfile.
//   - takes decoded instructions, blocks RAW/WAW hazards with a per-address
//     busy scoreboard, drives the regfile read ports straight from decode
//   - gathers the 1-cycle-latency operands and presents instruction plus
//     operands to execute over valid/ready
//   - forwards writebacks onto the regfile's single write port
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - regfile_issue_if.slave (decode, regfile, writeback, execute)
//   perf_issued_o, perf_hazard_stalls_o - only when REGFILE_ISSUE_PERF_EN is defined
// Optional feature macro: REGFILE_ISSUE_PERF_EN (issue / hazard-stall counters).
module regfile_issue #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 32,
  parameter int REG_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  regfile_issue_if.slave    bus
`ifdef REGFILE_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issued_o,
  output logic [31:0]       perf_hazard_stalls_o
`endif
);

  localparam int NENT = 1 << ADDR_W;

  // Register number 0 of every hart reads as zero and is never tracked.
  function automatic logic nz_reg(input logic [ADDR_W-1:0] a);
    return a[REG_BITS-1:0] != '0;
  endfunction

  // A busy address being written back this very cycle is not a hazard:
  // the regfile forwards wdata to a same-cycle read of that address.
  function automatic logic busy_eff(input logic [NENT-1:0]   b,
                                    input logic [ADDR_W-1:0] a,
                                    input logic              wbv,
                                    input logic [ADDR_W-1:0] wba);
    return b[a] && !(wbv && (wba == a));
  endfunction

  // Scoreboard
  logic [NENT-1:0]   busy_q, busy_d;

  // S1: the instruction handed to execute
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_waddr_q, s1_waddr_d;
  logic              s1_wen_q,   s1_wen_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  // fresh: S1 was loaded at the last edge, so rf_rs1/2 still carry its operands
  logic              fresh_q,    fresh_d;
  logic [DATA_W-1:0] hold_rs1_q, hold_rs1_d;
  logic [DATA_W-1:0] hold_rs2_q, hold_rs2_d;

  logic hazard, dec_ready, accept, drain, wb_clr, sb_set;

  // Handshake / hazard detection
  always_comb begin
    hazard = bus.dec_valid &&
             (busy_eff(busy_q, bus.dec_raddr1, bus.wb_valid, bus.wb_addr) ||
              busy_eff(busy_q, bus.dec_raddr2, bus.wb_valid, bus.wb_addr) ||
              (bus.dec_wen &&
               busy_eff(busy_q, bus.dec_waddr, bus.wb_valid, bus.wb_addr)));
  end

  assign drain     = s1_valid_q && bus.ex_ready;
  assign dec_ready = !hazard && (!s1_valid_q || bus.ex_ready);
  assign accept    = bus.dec_valid && dec_ready;
  assign wb_clr    = bus.wb_valid && nz_reg(bus.wb_addr);
  assign sb_set    = accept && bus.dec_wen && nz_reg(bus.dec_waddr);

  assign bus.dec_ready = dec_ready;

  // Regfile ports: reads follow decode every cycle so the regfile samples the
  // addresses at the same edge the instruction is accepted.
  assign bus.rf_raddr1 = bus.dec_raddr1;
  assign bus.rf_raddr2 = bus.dec_raddr2;
  assign bus.rf_waddr  = bus.wb_addr;
  assign bus.rf_wdata  = bus.wb_data;
  assign bus.rf_wren   = wb_clr;

  // Scoreboard next state; the set is applied last so it wins a same-address
  // collision with a writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) busy_d[bus.wb_addr]   = 1'b0;
    if (sb_set) busy_d[bus.dec_waddr] = 1'b1;
  end

  // S1 and operand hold next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_waddr_d = s1_waddr_q;
    s1_wen_d   = s1_wen_q;
    s1_tag_d   = s1_tag_q;
    fresh_d    = fresh_q;
    hold_rs1_d = hold_rs1_q;
    hold_rs2_d = hold_rs2_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_waddr_d = bus.dec_waddr;
      s1_wen_d   = bus.dec_wen;
      s1_tag_d   = bus.dec_tag;
      fresh_d    = 1'b1;
    end else if (drain) begin
      s1_valid_d = 1'b0;
      fresh_d    = 1'b0;
    end else if (fresh_q) begin
      // Stalled after the fresh cycle: the regfile will re-read whatever decode
      // now presents, so keep the operands that belong to this instruction.
      hold_rs1_d = bus.rf_rs1;
      hold_rs2_d = bus.rf_rs2;
      fresh_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_waddr_q <= '0;
      s1_wen_q   <= 1'b0;
      s1_tag_q   <= '0;
      fresh_q    <= 1'b0;
      hold_rs1_q <= '0;
      hold_rs2_q <= '0;
    end else begin
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_waddr_q <= s1_waddr_d;
      s1_wen_q   <= s1_wen_d;
      s1_tag_q   <= s1_tag_d;
      fresh_q    <= fresh_d;
      hold_rs1_q <= hold_rs1_d;
      hold_rs2_q <= hold_rs2_d;
    end
  end

  // Execute side
  assign bus.ex_valid = s1_valid_q;
  assign bus.ex_rs1   = fresh_q ? bus.rf_rs1 : hold_rs1_q;
  assign bus.ex_rs2   = fresh_q ? bus.rf_rs2 : hold_rs2_q;
  assign bus.ex_waddr = s1_waddr_q;
  assign bus.ex_wen   = s1_wen_q;
  assign bus.ex_tag   = s1_tag_q;

`ifdef REGFILE_ISSUE_PERF_EN
  // Hazard stalls only; cycles lost purely to execute backpressure are not counted.
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept) perf_issued_q <= perf_issued_q + 32'd1;
      if (hazard) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued_o        = perf_issued_q;
  assign perf_hazard_stalls_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_regfile_issue.sv
// Bench for regfile_issue: directed scenarios followed by random traffic.
// A driver issues one cycle of stimulus at a time, predicts dec_ready and the
// regfile write port from an architectural model, and queues the expected
// execute-side result of every accepted instruction. An independent monitor
// compares whatever the DUT presents to execute against that queue.
module tb_regfile_issue;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TW = 32;

  logic clk;
  logic rst;

  regfile_issue_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus ();

`ifdef REGFILE_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stalls;
`endif

  regfile_issue #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .REG_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REGFILE_ISSUE_PERF_EN
    ,
    .perf_issued_o        (perf_issued),
    .perf_hazard_stalls_o (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile: registered reads with same-cycle write forwarding; not reset.
  bit [DW-1:0] rf_mem [256];
  always @(posedge clk) begin
    bus.rf_rs1 <= (bus.rf_wren && bus.rf_waddr == bus.rf_raddr1) ? bus.rf_wdata : rf_mem[bus.rf_raddr1];
    bus.rf_rs2 <= (bus.rf_wren && bus.rf_waddr == bus.rf_raddr2) ? bus.rf_wdata : rf_mem[bus.rf_raddr2];
    if (bus.rf_wren) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  bit [DW-1:0] arch [256];   // architectural register values
  bit          pend [256];   // destination issued, result not yet written back
  int unsigned m_issued = 0;
  int unsigned m_stalls = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic bit nz(input logic [AW-1:0] a);
    return a[4:0] != 5'd0;
  endfunction

  // A pending register being written back in the same cycle is readable now.
  function automatic bit in_flight(input logic [AW-1:0] a, input bit wbv, input logic [AW-1:0] wba);
    return pend[a] && !(wbv && wba == a);
  endfunction

  // Value an accepted instruction sees: newest architectural value, zero for reg 0.
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a, input bit wbv,
                                       input logic [AW-1:0] wba, input logic [DW-1:0] wbd);
    if (!nz(a)) return '0;
    if (wbv && wba == a) return wbd;
    return arch[a];
  endfunction

  // Random address from a small pool (harts 0-3, registers 0-3) so hazards are common.
  function automatic logic [AW-1:0] ra();
    return AW'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3));
  endfunction

  // One clock of stimulus plus the checks that belong to it.
  task automatic cyc(input bit dv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                     input logic [AW-1:0] wa, input bit wen, input bit wbv,
                     input logic [AW-1:0] wba, input logic [DW-1:0] wbd, input bit exr);
    bit            haz, rdy, acc;
    logic [TW-1:0] tag;
    exp_t          e;
    tag = $urandom();
    @(negedge clk);
    bus.dec_valid  = dv;
    bus.dec_raddr1 = r1;
    bus.dec_raddr2 = r2;
    bus.dec_waddr  = wa;
    bus.dec_wen    = wen;
    bus.dec_tag    = tag;
    bus.wb_valid   = wbv;
    bus.wb_addr    = wba;
    bus.wb_data    = wbd;
    bus.ex_ready   = exr;
    #1;
    haz = dv && (in_flight(r1, wbv, wba) || in_flight(r2, wbv, wba) || (wen && in_flight(wa, wbv, wba)));
    rdy = !haz && (exp_q.size() == 0 || exr);
    chk("dec_ready", 64'(bus.dec_ready), 64'(rdy));
    chk("rf_raddr1", 64'(bus.rf_raddr1), 64'(r1));
    chk("rf_raddr2", 64'(bus.rf_raddr2), 64'(r2));
    chk("rf_wren", 64'(bus.rf_wren), 64'(wbv && nz(wba)));
    if (wbv) begin
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(wba));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(wbd));
    end
`ifdef REGFILE_ISSUE_PERF_EN
    chk("perf_issued", 64'(perf_issued), 64'(m_issued));
    chk("perf_hazard_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif
    acc     = dv && rdy;
    e.rs1   = rd(r1, wbv, wba, wbd);
    e.rs2   = rd(r2, wbv, wba, wbd);
    e.waddr = wa;
    e.wen   = wen;
    e.tag   = tag;
    if (wbv && nz(wba)) begin
      arch[wba] = wbd;
      pend[wba] = 1'b0;
    end
    if (acc && wen && nz(wa)) pend[wa] = 1'b1;
    if (haz) m_stalls++;
    if (acc) m_issued++;
    @(posedge clk);
    if (acc) exp_q.push_back(e);
  endtask

  task automatic idle(input bit exr);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, exr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.dec_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    exp_q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_issued = 0;
    m_stalls = 0;
    #1;
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'(0));
    chk("rst_dec_ready", 64'(bus.dec_ready), 64'(1));
    chk("rst_ex_rs1", 64'(bus.ex_rs1), 64'(0));
    chk("rst_ex_rs2", 64'(bus.ex_rs2), 64'(0));
    chk("rst_ex_waddr", 64'(bus.ex_waddr), 64'(0));
    chk("rst_ex_tag", 64'(bus.ex_tag), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t f;
    forever begin
      @(negedge clk);
      #2;
      chk("ex_valid", 64'(bus.ex_valid), 64'(exp_q.size() != 0));
      if (bus.ex_valid && exp_q.size() != 0) begin
        f = exp_q[0];
        chk("ex_rs1", 64'(bus.ex_rs1), 64'(f.rs1));
        chk("ex_rs2", 64'(bus.ex_rs2), 64'(f.rs2));
        chk("ex_waddr", 64'(bus.ex_waddr), 64'(f.waddr));
        chk("ex_wen", 64'(bus.ex_wen), 64'(f.wen));
        chk("ex_tag", 64'(bus.ex_tag), 64'(f.tag));
        if (bus.ex_ready) void'(exp_q.pop_front());
      end
    end
  end

`ifdef REGFILE_ISSUE_PERF_EN
  int unsigned s0, i0;
`endif

  // ---------------- driver ----------------
  initial begin : driver
    rst            = 1'b1;
    bus.dec_valid  = 1'b0;
    bus.dec_raddr1 = '0;
    bus.dec_raddr2 = '0;
    bus.dec_waddr  = '0;
    bus.dec_wen    = 1'b0;
    bus.dec_tag    = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus.ex_ready   = 1'b1;
    do_reset();

    // Basic read of two written registers
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h21, 32'hDEADBEEF, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h22, 32'h5, 1'b1);
    cyc(1'b1, 8'h21, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    idle(1'b1);

    // RAW hazard on 0x23, released by a same-cycle writeback
    cyc(1'b1, 8'h21, 8'h22, 8'h23, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
    cyc(1'b1, 8'h23, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cyc(1'b1, 8'h23, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cyc(1'b1, 8'h23, 8'h22, 8'h00, 1'b0, 1'b1, 8'h23, 32'h7, 1'b1);
    idle(1'b1);

    // Backpressure while the source is rewritten and re-read
    cyc(1'b1, 8'h21, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 8'h21, 8'h22, 8'h00, 1'b0, 1'b1, 8'h21, 32'(i * 32'h111), 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Zero register: not written, reads zero, never busy
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h40, 32'h1234, 1'b1);
    cyc(1'b1, 8'h40, 8'h21, 8'h40, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
    cyc(1'b1, 8'h40, 8'h40, 8'h40, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
    idle(1'b1);

    // Reset with S1 occupied and 0x23 busy
    cyc(1'b1, 8'h21, 8'h22, 8'h23, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
    do_reset();
    cyc(1'b1, 8'h23, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h23, 32'h9, 1'b1);
    idle(1'b1);

`ifdef REGFILE_ISSUE_PERF_EN
    // Three-cycle hazard stall then issue
    cyc(1'b1, 8'h21, 8'h22, 8'h24, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
    s0 = m_stalls;
    repeat (3) cyc(1'b1, 8'h24, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    i0 = m_issued;
    cyc(1'b1, 8'h24, 8'h21, 8'h00, 1'b0, 1'b1, 8'h24, 32'h55, 1'b1);
    idle(1'b1);
    #1;
    chk("perf_stall_delta", 64'(perf_stalls), 64'(s0 + 3));
    chk("perf_issue_delta", 64'(perf_issued), 64'(i0 + 1));
`endif

    // Random traffic with occasional mid-run resets
    for (int n = 0; n < 1500; n++) begin
      if (n % 400 == 399) do_reset();
      cyc($urandom_range(0, 9) < 7, ra(), ra(), ra(), $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 4, ra(), $urandom(), $urandom_range(0, 9) < 7);
    end

    repeat (3) idle(1'b1);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
